// File: rtl/riego_pkg.sv
// Shared constants for the pot-watering scheduler: FSM encodings, pot size codes
// and default timing for a 50 MHz clock.
package riego_pkg;

  typedef logic [1:0] estado_t;

  localparam estado_t S_IDLE   = 2'd0;
  localparam estado_t S_ABRIR  = 2'd1;
  localparam estado_t S_REGAR  = 2'd2;
  localparam estado_t S_CERRAR = 2'd3;

  localparam logic [3:0] TAM_30S = 4'd1;
  localparam logic [3:0] TAM_60S = 4'd2;
  localparam logic [3:0] TAM_90S = 4'd3;

  localparam longint unsigned TICKS_UNIDAD_DEF = 64'd1_500_000_000;
  localparam int unsigned     T_VALV_DEF       = 50_000;

  // Only codes 1..3 map to a watering length; anything else is rejected at grant.
  function automatic logic tam_valida(input logic [3:0] tam);
    return (tam >= TAM_30S) && (tam <= TAM_90S);
  endfunction

endpackage

// File: rtl/riego_scheduler_if.sv
// Pump/valve control bundle between the scheduler and its environment.
interface riego_scheduler_if #(
  parameter int unsigned N_MACETAS = 4
);

  logic                     mod_bomba;
  logic [N_MACETAS-1:0]     regar_req;
  logic [4*N_MACETAS-1:0]   maceta_tam;
  logic                     activar_bomba;
  logic [N_MACETAS-1:0]     valvula;
  logic                     ocupado;
  logic [N_MACETAS-1:0]     regado_done;
  logic [N_MACETAS-1:0]     error_tam;

  modport master (
    output mod_bomba, regar_req, maceta_tam,
    input  activar_bomba, valvula, ocupado, regado_done, error_tam
  );

  modport slave (
    input  mod_bomba, regar_req, maceta_tam,
    output activar_bomba, valvula, ocupado, regado_done, error_tam
  );

endinterface

// File: rtl/riego_scheduler_arbitro_rr.sv
// Round-robin pick of one pending pot, searching upward from the pointer with wrap.
module arbitro_rr #(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  pending_i,
  input  logic [PW-1:0] pointer_i,
  output logic [N-1:0]  grant_o,
  output logic          valid_o
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < int'(N); k++) begin
      idx = PW'((int'(pointer_i) + k) % int'(N));
      if (!found && pending_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  assign valid_o = |pending_i;

endmodule

// File: rtl/riego_scheduler.sv
// Shares one pump among N pots: sticky requests, round-robin grant, valve open,
// timed pump run scaled by pot size, valve close, done pulse.
module riego_scheduler
  import riego_pkg::*;
#(
  parameter int unsigned     N_MACETAS    = 4,
  parameter longint unsigned TICKS_UNIDAD = TICKS_UNIDAD_DEF,
  parameter int unsigned     T_VALV       = T_VALV_DEF
) (
  input logic             clk,
  input logic             rst_n,
  riego_scheduler_if.slave bus
);

  localparam longint unsigned MAX_DUR  = 3 * TICKS_UNIDAD;
  localparam int unsigned     CW       = $clog2(MAX_DUR + 1);
  localparam int unsigned     PW       = (N_MACETAS > 1) ? $clog2(N_MACETAS) : 1;
  localparam logic [CW-1:0]   FIN_VALV = CW'(T_VALV - 1);
  localparam logic [CW-1:0]   TICKS_W  = CW'(TICKS_UNIDAD);

  estado_t                state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [N_MACETAS-1:0]   pend_q, pend_d, sel_q, sel_d;
  logic [PW-1:0]          ptr_q, ptr_d, idx_q, idx_d;
  logic [1:0]             tam_q, tam_d;
  logic                   bomba_q, bomba_d, ocup_q, ocup_d;
  logic [N_MACETAS-1:0]   valv_q, valv_d, done_q, done_d, err_q, err_d;

  logic [N_MACETAS-1:0]   grant;
  logic                   grant_valid;
  logic [PW-1:0]          g_idx;
  logic [3:0]             g_tam;
  logic [CW-1:0]          fin_regar;

  function automatic logic [PW-1:0] sig_ptr(input logic [PW-1:0] i);
    return (i == PW'(N_MACETAS - 1)) ? '0 : i + PW'(1);
  endfunction

  arbitro_rr #(.N(N_MACETAS)) u_arbitro (
    .pending_i (pend_q),
    .pointer_i (ptr_q),
    .grant_o   (grant),
    .valid_o   (grant_valid)
  );

  // Index and size code of the pot the arbiter picked this cycle.
  always_comb begin
    g_idx = '0;
    g_tam = '0;
    for (int i = 0; i < int'(N_MACETAS); i++) begin
      if (grant[i]) begin
        g_idx = PW'(i);
        g_tam = bus.maceta_tam[4*i +: 4];
      end
    end
  end

  assign fin_regar = CW'(tam_q) * TICKS_W - CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    pend_d  = pend_q | bus.regar_req;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    tam_d   = tam_q;
    done_d  = '0;
    err_d   = '0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (grant_valid && bus.mod_bomba) begin
          if (tam_valida(g_tam)) begin
            state_d = S_ABRIR;
            sel_d   = grant;
            idx_d   = g_idx;
            tam_d   = g_tam[1:0];
          end else begin
            err_d  = grant;
            pend_d = pend_d & ~grant;
            ptr_d  = sig_ptr(g_idx);
          end
        end
      end
      S_ABRIR: begin
        if (cnt_q == FIN_VALV) begin
          state_d = S_REGAR;
          cnt_d   = '0;
        end
      end
      S_REGAR: begin
        if (cnt_q == fin_regar) begin
          state_d = S_CERRAR;
          cnt_d   = '0;
        end
      end
      S_CERRAR: begin
        if (cnt_q == FIN_VALV) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = sel_q;
          pend_d  = pend_d & ~sel_q;
          ptr_d   = sig_ptr(idx_q);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Pump module lost: drop everything, keep the request and pointer for a retry.
    if ((state_q != S_IDLE) && !bus.mod_bomba) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      done_d  = '0;
      pend_d  = pend_q | bus.regar_req;
      ptr_d   = ptr_q;
    end

    ocup_d  = (state_d != S_IDLE);
    bomba_d = (state_d == S_REGAR);
    valv_d  = (state_d != S_IDLE) ? sel_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      tam_q   <= '0;
      bomba_q <= 1'b0;
      ocup_q  <= 1'b0;
      valv_q  <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      tam_q   <= tam_d;
      bomba_q <= bomba_d;
      ocup_q  <= ocup_d;
      valv_q  <= valv_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.activar_bomba = bomba_q;
  assign bus.valvula       = valv_q;
  assign bus.ocupado       = ocup_q;
  assign bus.regado_done   = done_q;
  assign bus.error_tam     = err_q;

endmodule

// File: doc/riego_scheduler.md
RIEGO_SCHEDULER -- requirements
Module: riego_scheduler

Interface
REQ-001 SHALL have parameter N_MACETAS, default 4, number of pots sharing one pump.
REQ-002 SHALL have parameter TICKS_UNIDAD, default 1_500_000_000, cycles per 30 s watering unit at 50 MHz.
REQ-003 SHALL have parameter T_VALV, default 50_000, valve settle cycles before pump-on and after pump-off.
REQ-004 SHALL have ports in this order:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mod_bomba  in  1  pump module connected.
- regar_req  in  N_MACETAS  per-pot watering request, level or pulse.
- maceta_tam  in  4*N_MACETAS  per-pot size code, pot i at bits [4i+3:4i].
- activar_bomba  out  1  pump drive.
- valvula  out  N_MACETAS  one-hot valve select, all-zero when idle.
- ocupado  out  1  high in any state other than IDLE.
- regado_done  out  N_MACETAS  one-cycle pulse on completed watering of pot i.
- error_tam  out  N_MACETAS  one-cycle pulse when pot i is granted with an invalid size.

Function
REQ-005 SHALL latch each regar_req bit into a sticky pending bit on every rising edge where it is high, including while mod_bomba is low.
REQ-006 SHALL implement FSM states IDLE, ABRIR, REGAR, CERRAR.
REQ-007 IDLE with any pending bit and mod_bomba=1 SHALL grant one pot round-robin, starting at the pointer, and enter ABRIR on the next edge.
REQ-008 SHALL hold valvula one-hot on the granted pot throughout ABRIR, REGAR and CERRAR; activar_bomba SHALL be high only in REGAR.
REQ-009 ABRIR SHALL last exactly T_VALV cycles.
REQ-010 REGAR SHALL last exactly tam*TICKS_UNIDAD cycles, where tam is the granted pot's maceta_tam sampled at grant; tam 1/2/3 gives 30/60/90 s.
REQ-011 tam 0 or tam>3 at grant SHALL pulse error_tam[i], clear pending[i], advance the pointer, and return to IDLE without opening the valve.
REQ-012 CERRAR SHALL last exactly T_VALV cycles with the pump off.
REQ-013 Leaving CERRAR SHALL:
- pulse regado_done[i] for one cycle;
- clear pending[i];
- set the pointer to i+1 modulo N_MACETAS;
- enter IDLE.
REQ-014 A request from the granted pot during its service SHALL be absorbed, not re-queued.
REQ-015 mod_bomba falling in any non-IDLE state SHALL, on the next edge:
- set activar_bomba=0 and valvula=0;
- enter IDLE;
- retain pending[i] and the pointer;
- emit no done pulse.
REQ-016 The duration counter SHALL be $clog2(3*TICKS_UNIDAD+1) bits wide, SHALL be compared without overflow, and SHALL clear on every state entry.
REQ-017 Simultaneous pending completion clear and new regar_req on the same pot and edge SHALL leave pending set only if the pot is not the one being serviced.

Reset
REQ-018 rst_n low SHALL asynchronously force:
- state to IDLE;
- pending, pointer, counter and latched size to 0;
- activar_bomba=0, valvula=0, ocupado=0, regado_done=0, error_tam=0.
REQ-019 Reset asserted mid-watering SHALL turn the pump off immediately, without waiting for a clock edge.

Structure
REQ-020 Package riego_pkg SHALL hold the state enum, the size codes and the default TICKS_UNIDAD/T_VALV constants.
REQ-021 Round-robin selection SHALL be a sub-module arbitro_rr (inputs: pending, pointer; outputs: one-hot grant, valid).

Verification (TICKS_UNIDAD=10, T_VALV=2, N_MACETAS=4)
REQ-022 Single request:
- stimulus: pulse regar_req[1] with tam1=2;
- response: valvula=0010 for 2+20+2 cycles, activar_bomba high exactly 20 cycles, regado_done[1] pulses once.
REQ-023 Round-robin:
- stimulus: pots 0, 2 and 3 requested together, pointer at 0;
- response: service order 0, 2, 3, with 3 done pulses.
REQ-024 Invalid size:
- stimulus: request pot 0 with tam0=0;
- response: error_tam[0] pulses, the pump never turns on, the next pending pot is served.
REQ-025 Abort:
- stimulus: drop mod_bomba at cycle 5 of REGAR;
- response: pump and valve off on the next edge, no done pulse; after mod_bomba returns, the same pot re-waters its full 10*tam cycles.
REQ-026 Reset mid-watering:
- stimulus: assert rst_n=0 in REGAR;
- response: activar_bomba=0 before the next edge, all outputs 0, the pending request is lost.
